// File: rtl/enoc_source_queue.sv
`default_nettype none
// ============================================================================
// Module   : enoc_source_queue
// Purpose  : Node-side injection buffer placed directly upstream of one local
//            port of the ENoC network. Packets offered by the node traffic
//            source are held in a first-word-fall-through FIFO, and the head
//            packet is presented to the network local input using the
//            network's valid/enable handshake. Offers refused while the queue
//            is full are counted in a saturating counter, so the node keeps
//            visibility of back-pressure losses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PACKET_WIDTH   : bits per packet (matches the network packet width)
//   DEPTH          : number of FIFO entries, power of two, >= 2
//   DROP_CNT_WIDTH : width of the saturating drop counter
// Ports
//   clk          in   1                 single clock, rising edge
//   reset_n      in   1                 asynchronous active-low reset
//   i_data       in   PACKET_WIDTH      packet offered by the node source
//   i_data_val   in   1                 i_data is valid
//   o_en         out  1                 queue can accept (push = val & en)
//   o_data       out  PACKET_WIDTH      head packet to the network
//   o_data_val   out  1                 head valid (queue non-empty)
//   i_en         in   1                 network enable (pop = val & en)
//   o_occupancy  out  $clog2(DEPTH)+1   entry count, 0..DEPTH
//   o_drop_cnt   out  DROP_CNT_WIDTH    refused offers, saturating
// ============================================================================
module enoc_source_queue #(
  parameter int PACKET_WIDTH   = 64,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [PACKET_WIDTH-1:0]    i_data,
  input  logic                       i_data_val,
  output logic                       o_en,
  output logic [PACKET_WIDTH-1:0]    o_data,
  output logic                       o_data_val,
  input  logic                       i_en,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic [DROP_CNT_WIDTH-1:0]  o_drop_cnt
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int OCC_WIDTH  = ADDR_WIDTH + 1;

  localparam logic [OCC_WIDTH-1:0]      FULL_COUNT = OCC_WIDTH'(DEPTH);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX   = {DROP_CNT_WIDTH{1'b1}};

  // Pointer wrap relies on natural binary overflow, which is only correct
  // when DEPTH is an exact power of two.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("enoc_source_queue: DEPTH must be a power of two and >= 2");
    end
    if (DROP_CNT_WIDTH < 1) begin : g_bad_drop_width
      $error("enoc_source_queue: DROP_CNT_WIDTH must be >= 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PACKET_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic [OCC_WIDTH-1:0]      occupancy;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  // --------------------------------------------------------------------------
  // Handshake decode. Both flags depend only on registered state plus the
  // partner's valid/enable, so no input ever reaches an output
  // combinationally.
  // --------------------------------------------------------------------------
  logic not_full;
  logic not_empty;
  logic push;
  logic pop;
  logic drop;

  assign not_full  = (occupancy != FULL_COUNT);
  assign not_empty = (occupancy != '0);
  assign push      = i_data_val & not_full;
  assign pop       = not_empty & i_en;
  // A full queue refuses the offer even if a pop frees a slot this cycle;
  // the freed slot becomes visible through o_en on the next cycle.
  assign drop      = i_data_val & ~not_full;

  // --------------------------------------------------------------------------
  // Storage. The array carries no reset: after reset the occupancy counter
  // is zero, so whatever the array still holds is unreachable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;  // idle, or push and pop cancel
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating drop counter: sticks at all-ones rather than wrapping, so a
  // large value always means "at least this many lost".
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_en        = not_full;
  assign o_data_val  = not_empty;
  assign o_data      = mem[rd_ptr];
  assign o_occupancy = occupancy;
  assign o_drop_cnt  = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enoc_source_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_enoc_source_queue
// Purpose  : Self-checking bench for enoc_source_queue. Directed vector table
//            for fill/drop/drain, hand-written sequences for streaming,
//            mid-stream reset and drop-counter saturation (second instance
//            with a 4-bit counter), and randomized traffic compared against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enoc_source_queue;

  localparam int PW    = 64;
  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [PW-1:0] i_data;
  logic          i_data_val;
  logic          i_en;
  logic          o_en;
  logic [PW-1:0] o_data;
  logic          o_data_val;
  logic [3:0]    o_occupancy;
  logic [DW-1:0] o_drop_cnt;

  // Second instance with a narrow drop counter for the saturation check.
  logic [PW-1:0] s_data;
  logic          s_data_val;
  logic          s_en;
  logic          s_o_en;
  logic [PW-1:0] s_o_data;
  logic          s_o_data_val;
  logic [3:0]    s_occupancy;
  logic [3:0]    s_drop_cnt;

  enoc_source_queue #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_data      (i_data),
    .i_data_val  (i_data_val),
    .o_en        (o_en),
    .o_data      (o_data),
    .o_data_val  (o_data_val),
    .i_en        (i_en),
    .o_occupancy (o_occupancy),
    .o_drop_cnt  (o_drop_cnt)
  );

  enoc_source_queue #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(4)) dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_data      (s_data),
    .i_data_val  (s_data_val),
    .o_en        (s_o_en),
    .o_data      (s_o_data),
    .o_data_val  (s_o_data_val),
    .i_en        (s_en),
    .o_occupancy (s_occupancy),
    .o_drop_cnt  (s_drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a packet queue plus a drop tally, updated from the
  // handshake rules on every clock of the main instance.
  // --------------------------------------------------------------------------
  logic [PW-1:0] mq[$];
  int            mdrop;

  task automatic model_reset();
    mq.delete();
    mdrop = 0;
  endtask

  task automatic model_step(input logic v, input logic [PW-1:0] d, input logic e);
    bit accept;
    bit take;
    accept = v && (mq.size() < DEPTH);
    take   = e && (mq.size() > 0);
    if (v && !accept && mdrop < (1 << DW) - 1) mdrop++;
    if (take) void'(mq.pop_front());
    if (accept) mq.push_back(d);
  endtask

  task automatic model_check(input int n);
    string s;
    s = $sformatf("rnd%0d", n);
    chk({s, ".occ"},  o_occupancy, mq.size());
    chk({s, ".dval"}, o_data_val, mq.size() != 0);
    chk({s, ".en"},   o_en, mq.size() != DEPTH);
    chk({s, ".drop"}, o_drop_cnt, mdrop);
    if (mq.size() != 0) chk({s, ".data"}, o_data, mq[0]);
  endtask

  // One clock of the main instance: drive after the falling edge, let the
  // rising edge act, then sample 1 time unit later.
  task automatic cycle(input logic v, input logic [PW-1:0] d, input logic e);
    @(negedge clk);
    i_data_val = v;
    i_data     = d;
    i_en       = e;
    @(posedge clk);
    model_step(v, d, e);
    #1;
  endtask

  task automatic cycle4(input logic v, input logic [PW-1:0] d, input logic e);
    @(negedge clk);
    s_data_val = v;
    s_data     = d;
    s_en       = e;
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table: inputs applied for one cycle, then the expected
  // outputs after that clock edge.
  // --------------------------------------------------------------------------
  typedef struct {
    logic          val;
    logic [PW-1:0] data;
    logic          en;
    logic [3:0]    occ;
    logic          dval;
    logic          oen;
    logic          chk_data;
    logic [PW-1:0] exp_data;
    logic [DW-1:0] drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [PW-1:0] d, input logic e,
                     input logic [3:0] occ, input logic dv, input logic oe,
                     input logic cd, input logic [PW-1:0] ed, input logic [DW-1:0] dr);
    vec_t r;
    r.val = v; r.data = d; r.en = e; r.occ = occ; r.dval = dv; r.oen = oe;
    r.chk_data = cd; r.exp_data = ed; r.drop = dr;
    tbl.push_back(r);
  endtask

  initial begin
    logic [PW-1:0] pk;

    // ---- table construction -------------------------------------------------
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, 0, 0, 0);                // idle
    for (int i = 1; i <= 8; i++) begin                                          // fill, head held
      pk = 64'h11 * i;
      add(1, pk, 0, 4'(i), 1, (i != 8), 1, 64'h11, 0);
    end
    add(1, 64'h99, 0, 8, 1, 0, 1, 64'h11, 1);                                    // refused offer
    add(1, 64'h99, 1, 7, 1, 1, 1, 64'h22, 2);                                    // pop+offer when full: no push
    for (int k = 2; k <= 8; k++) begin                                          // drain
      pk = 64'h11 * (k + 1);
      add(0, 0, 1, 4'(8 - k), (k != 8), 1, (k != 8), pk, 2);
    end
    add(0, 0, 1, 0, 0, 1, 0, 0, 2);                                              // pop on empty ignored

    // ---- reset ---------------------------------------------------------------
    reset_n = 1'b0;
    i_data = '0; i_data_val = 1'b0; i_en = 1'b0;
    s_data = '0; s_data_val = 1'b0; s_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.occ",  o_occupancy, 0);
    chk("rst.dval", o_data_val, 0);
    chk("rst.en",   o_en, 1);
    chk("rst.drop", o_drop_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- table-driven vectors -------------------------------------------------
    foreach (tbl[i]) begin
      string s;
      cycle(tbl[i].val, tbl[i].data, tbl[i].en);
      s = $sformatf("vec%0d", i);
      chk({s, ".occ"},  o_occupancy, tbl[i].occ);
      chk({s, ".dval"}, o_data_val,  tbl[i].dval);
      chk({s, ".en"},   o_en,        tbl[i].oen);
      chk({s, ".drop"}, o_drop_cnt,  tbl[i].drop);
      if (tbl[i].chk_data) chk({s, ".data"}, o_data, tbl[i].exp_data);
    end

    // ---- streaming from empty: 1-cycle latency, occupancy holds at 1 ----------
    for (int p = 0; p < 20; p++) begin
      cycle(1, 64'h1000 + p, 1);
      chk($sformatf("stream%0d.occ", p),  o_occupancy, 1);
      chk($sformatf("stream%0d.data", p), o_data, 64'h1000 + p);
      chk($sformatf("stream%0d.en", p),   o_en, 1);
    end
    cycle(0, 0, 1);
    chk("stream.end.dval", o_data_val, 0);
    chk("stream.end.drop", o_drop_cnt, 2);

    // ---- asynchronous reset mid-stream ----------------------------------------
    for (int p = 0; p < 3; p++) cycle(1, 64'h500 + p, 0);
    chk("pre_rst.occ", o_occupancy, 3);
    @(negedge clk);
    i_data_val = 1'b0;
    i_en       = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.dval", o_data_val, 0);
    chk("async_rst.occ",  o_occupancy, 0);
    chk("async_rst.drop", o_drop_cnt, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1, 64'hAB, 0);
    chk("post_rst.occ",  o_occupancy, 1);
    chk("post_rst.data", o_data, 64'hAB);
    cycle(0, 0, 1);
    chk("post_rst.empty", o_data_val, 0);

    // ---- randomized traffic against the reference model -----------------------
    for (int n = 0; n < 400; n++) begin
      int vp;
      int ep;
      vp = ((n / 50) % 2 == 0) ? 80 : 25;
      ep = ((n / 50) % 2 == 0) ? 25 : 80;
      cycle(($urandom_range(0, 99) < vp), {$urandom, $urandom}, ($urandom_range(0, 99) < ep));
      model_check(n);
    end

    // ---- drop counter saturation on the 4-bit instance -------------------------
    for (int p = 0; p < 8; p++) cycle4(1, 64'h700 + p, 0);
    chk("sat.full.en",  s_o_en, 0);
    chk("sat.full.occ", s_occupancy, 8);
    for (int k = 1; k <= 20; k++) begin
      cycle4(1, 64'hDEAD, 0);
      chk($sformatf("sat%0d.drop", k), s_drop_cnt, (k > 15) ? 15 : k);
    end
    chk("sat.head", s_o_data, 64'h700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
